// File: rtl/tdm_mux_tx_pkg.sv
// Shared definitions for the TDM serial link (transmitter and demux receiver).
// Holds default frame geometry, derived counter widths, the FSM state encoding
// and small width helpers usable from parameterised modules and interfaces.
package tdm_mux_tx_pkg;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of the channel index; never narrower than one bit.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Width of the frame bit counter (0 .. nch*w-1).
    function automatic int cnt_width(input int nch, input int w);
        return (nch * w > 1) ? $clog2(nch * w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(NCH_DEF, W_DEF);
    localparam int SEL_W = sel_width(NCH_DEF);

endpackage

// File: rtl/tdm_mux_tx_if.sv
// Parallel-side interface of the TDM transmitter.
//   load    : capture request (master -> slave)
//   ch_data : NCH packed channel words, channel c at [c*W +: W]
//   ready   : a capture would be accepted at the next edge
//   busy    : frame in progress
//   sd      : serial data, MSB first, channel 0 first
//   sync    : high during frame bit 0
//   ch_sel  : index of the channel currently on sd
interface tdm_mux_tx_if
    import tdm_mux_tx_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) ();

    localparam int SEL_W_L = sel_width(NCH);

    logic                 load;
    logic [NCH*W-1:0]     ch_data;
    logic                 ready;
    logic                 busy;
    logic                 sd;
    logic                 sync;
    logic [SEL_W_L-1:0]   ch_sel;

    modport master (
        output load, ch_data,
        input  ready, busy, sd, sync, ch_sel
    );

    modport slave (
        input  load, ch_data,
        output ready, busy, sd, sync, ch_sel
    );

endinterface

// File: rtl/tdm_mux_tx_piso_shift.sv
// N-bit parallel-in / serial-out shift register.
//   clk, rst : clock, asynchronous active-high reset (clears the register)
//   load     : capture d (has priority over shift_en)
//   shift_en : shift left by one, zero fill
//   d        : parallel input
//   q        : current MSB
module piso_shift #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [N-1:0] d,
    output logic         q
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift_en) begin
            sr_d = {sr_q[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[N-1];

endmodule

// File: rtl/tdm_mux_tx.sv
// TDM serial transmitter: captures NCH words of W bits and sends them as one
// frame, channel 0 first, MSB first, with a frame sync on bit 0 and a channel
// index alongside. Back-to-back frames are possible with no gap cycle.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : tdm_mux_tx_if slave (load, ch_data in; ready, busy, sd, sync, ch_sel out)
module tdm_mux_tx
    import tdm_mux_tx_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    tdm_mux_tx_if.slave   bus
);

    localparam int NBITS  = NCH * W;
    localparam int CNT_WL = cnt_width(NCH, W);
    localparam int SEL_WL = sel_width(NCH);
    localparam int POS_W  = (W > 1) ? $clog2(W) : 1;

    state_e              state_q, state_d;
    logic [CNT_WL-1:0]   bit_cnt_q, bit_cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [SEL_WL-1:0]   ch_sel_q, ch_sel_d;
    logic                load_en;
    logic                shift_en;
    logic                last;
    logic                msb;
    logic [NBITS-1:0]    frame;

    // Channel 0 goes to the top of the shift register so it leaves first.
    always_comb begin
        frame = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            frame[(NCH - 1 - c) * W +: W] = bus.ch_data[c * W +: W];
        end
    end

    assign last = (bit_cnt_q == CNT_WL'(NBITS - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pos_d     = pos_q;
        ch_sel_d  = ch_sel_q;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    load_en   = 1'b1;
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    pos_d     = '0;
                    ch_sel_d  = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    // Counters restart either way; a load here chains the next frame.
                    bit_cnt_d = '0;
                    pos_d     = '0;
                    ch_sel_d  = '0;
                    if (bus.load) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_WL'(1);
                    // Channel index advances once the LSB of a word has been sent.
                    if (pos_q == POS_W'(W - 1)) begin
                        pos_d    = '0;
                        ch_sel_d = ch_sel_q + SEL_WL'(1);
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            pos_q     <= '0;
            ch_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pos_q     <= pos_d;
            ch_sel_q  <= ch_sel_d;
        end
    end

    piso_shift #(
        .N (NBITS)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load_en),
        .shift_en (shift_en),
        .d        (frame),
        .q        (msb)
    );

    assign bus.busy   = (state_q == SHIFT);
    assign bus.ready  = (state_q == IDLE) || ((state_q == SHIFT) && last);
    assign bus.sd     = (state_q == SHIFT) && msb;
    assign bus.sync   = (state_q == SHIFT) && (bit_cnt_q == '0);
    assign bus.ch_sel = ch_sel_q;

endmodule
